usb_fs_bit_rx: RTL
==================

USB_FS_BIT_RX -- requirements
Module: usb_fs_bit_rx

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state SHALL sit in the single clock domain.
REQ-002 clk_48mhz  in  1  system clock, 4x the USB full-speed bit rate (12 Mb/s).
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 usb_p_rx  in  1  raw D+ from the pad mux; forced to 1 while the FPGA transmits.
REQ-005 usb_n_rx  in  1  raw D- from the pad mux; forced to 0 while the FPGA transmits.
REQ-006 rx_en  in  1  receive enable; 0 = ignore the bus.
REQ-007 line_state  out  2  synchronized {p,n}: 10 = J, 01 = K, 00 = SE0, 11 = SE1.
REQ-008 pkt_start  out  1  one-cycle pulse when SYNC completes.
REQ-009 rx_data  out  8  last assembled byte, LSB received first.
REQ-010 rx_data_valid  out  1  one-cycle pulse when rx_data updates.
REQ-011 pkt_end  out  1  one-cycle pulse at the end of EOP.
REQ-012 pkt_error  out  1  one-cycle pulse on a stuff, SE1 or partial-byte error.

Function
REQ-013 Inputs SHALL pass a 2-flop synchronizer; line_state SHALL be the 2nd-stage value, 2 cycles of latency.
REQ-014 Phase counter (2 bit): SHALL clear to 0 on any line_state change, otherwise increment mod 4; a bit sample SHALL be taken when the counter equals 2.
REQ-015 NRZI decode: on each sample, bit = 1 if the sampled J/K equals the previous sampled J/K, else 0; after reset the previous sample is J.
REQ-016 States SHALL be IDLE, SYNC, DATA and EOP; reset and rx_en=0 SHALL force IDLE, with no pulses while rx_en=0.
REQ-017 IDLE -> SYNC on the first K sample; the zero-run counter SHALL start at 1.
REQ-018 In SYNC, a 0 bit SHALL increment the zero-run counter, saturating at 7.
REQ-019 In SYNC, a 1 bit with zero-run >= 3 SHALL go to DATA and pulse pkt_start the next cycle.
REQ-020 In SYNC, a 1 bit with zero-run < 3, or an SE0 or SE1 sample, SHALL return to IDLE with no pulse.
REQ-021 In DATA, bits SHALL shift LSB-first into a byte register, counted by a 3-bit counter that wraps at 8.
REQ-022 On the 8th bit, rx_data SHALL load and rx_data_valid SHALL pulse the cycle after that sample; rx_data SHALL hold otherwise.
REQ-023 Bit unstuffing: a ones-run counter SHALL span byte boundaries and clear on every 0 bit.
REQ-024 After six consecutive 1s, the next bit SHALL be discarded if 0 (not counted, run cleared).
REQ-025 If the bit after six consecutive 1s is 1, pkt_error SHALL pulse and the state SHALL go to EOP.
REQ-026 An SE0 sample in DATA SHALL go to EOP; if the bit counter != 0, pkt_error SHALL pulse and the partial byte SHALL be dropped.
REQ-027 An SE1 sample in DATA SHALL pulse pkt_error and go to EOP.
REQ-028 In EOP, the first J sample SHALL pulse pkt_end and go to IDLE; K, SE0 or SE1 samples SHALL keep the state in EOP.
REQ-029 At most one of pkt_start, rx_data_valid and pkt_end SHALL pulse in any cycle; pkt_error MAY coincide only with the EOP entry cycle.

Reset
REQ-030 While reset=1: all pulse outputs = 0, rx_data = 0x00, line_state = 10 (J), state = IDLE, all counters = 0, previous sample = J.
REQ-031 Reset asserted mid-packet SHALL abort immediately with no pkt_end or pkt_error.
REQ-032 After reset is released, operation SHALL resume from IDLE.

Verification
REQ-033 Reset with the bus idle at J -> all outputs 0; line_state = 10 two cycles after release.
REQ-034 SYNC KJKJKJKK + byte 0xA5 + SE0,SE0,J at 4 cycles/bit -> one pkt_start, one rx_data_valid with rx_data = 0xA5, one pkt_end, no pkt_error.
REQ-035 Byte 0xFF sent with a stuffed 0 after the 6th 1 -> rx_data = 0xFF, no error.
REQ-036 Seven 1s sent (no stuffed 0) -> pkt_error, then pkt_end on J.
REQ-037 Same packet with bit widths alternating 3 and 5 cycles -> identical 0xA5 result.
REQ-038 SE0 after 12 data bits -> one rx_data_valid, then pkt_error and pkt_end.
REQ-039 rx_en dropped mid-byte -> IDLE with no further pulses.

Source files
------------

// File: rtl/usb_fs_bit_rx.sv
// USB full-speed receive front end: input synchronizer, 4x oversampling
// bit recovery, NRZI decode, SYNC detection, bit unstuffing, byte assembly
// and EOP detection. Status is reported as single-cycle pulses.
module usb_fs_bit_rx (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       pkt_start,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       pkt_end,
    output logic       pkt_error
);

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } state_t;

    logic [1:0] meta_q, meta_d;
    logic [1:0] line_q, line_d;
    logic [1:0] line_prev_q, line_prev_d;
    logic [1:0] phase_q, phase_d;
    logic       prev_j_q, prev_j_d;
    state_t     state_q, state_d;
    logic [2:0] zeros_q, zeros_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       start_q, start_d;
    logic       valid_q, valid_d;
    logic       end_q, end_d;
    logic       error_q, error_d;

    logic sample;
    logic is_j;
    logic is_k;
    logic is_jk;
    logic bit_val;

    // Synchronizer stages and phase tracking for the bit sampler.
    always_comb begin
        meta_d      = {usb_p_rx, usb_n_rx};
        line_d      = meta_q;
        line_prev_d = line_q;
        // The count for the current cycle restarts at every edge, so a
        // sample lands two cycles into each bit even for short bits.
        phase_d     = (line_q != line_prev_q) ? 2'd0 : phase_q + 2'd1;
        sample      = (phase_d == 2'd2);
        is_j        = (line_q == LS_J);
        is_k        = (line_q == LS_K);
        is_jk       = is_j | is_k;
        bit_val     = (is_j == prev_j_q);
        prev_j_d    = (sample && is_jk) ? is_j : prev_j_q;
    end

    // Packet state machine: SYNC hunt, unstuffing, byte assembly, EOP.
    always_comb begin
        state_d   = state_q;
        zeros_d   = zeros_q;
        ones_d    = ones_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        end_d     = 1'b0;
        error_d   = 1'b0;
        if (!rx_en) begin
            state_d  = ST_IDLE;
            zeros_d  = '0;
            ones_d   = '0;
            bitcnt_d = '0;
            shift_d  = '0;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_k) begin
                        state_d = ST_SYNC;
                        zeros_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_jk) begin
                        state_d = ST_IDLE;
                    end else if (!bit_val) begin
                        zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
                    end else if (zeros_q >= 3'd3) begin
                        state_d  = ST_DATA;
                        start_d  = 1'b1;
                        ones_d   = '0;
                        bitcnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (line_q == LS_SE0) begin
                        state_d = ST_EOP;
                        error_d = (bitcnt_q != 3'd0);
                    end else if (line_q == LS_SE1) begin
                        state_d = ST_EOP;
                        error_d = 1'b1;
                    end else if (ones_q == 3'd6) begin
                        // Bit following six ones: a 0 is stuffing, a 1 is illegal.
                        if (bit_val) begin
                            state_d = ST_EOP;
                            error_d = 1'b1;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        shift_d  = {bit_val, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        ones_d   = bit_val ? ones_q + 3'd1 : 3'd0;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_d = {bit_val, shift_q[7:1]};
                            valid_d   = 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (is_j) begin
                        state_d = ST_IDLE;
                        end_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // All state registers share the asynchronous reset.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            meta_q      <= LS_J;
            line_q      <= LS_J;
            line_prev_q <= LS_J;
            phase_q     <= '0;
            prev_j_q    <= 1'b1;
            state_q     <= ST_IDLE;
            zeros_q     <= '0;
            ones_q      <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            end_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            line_q      <= line_d;
            line_prev_q <= line_prev_d;
            phase_q     <= phase_d;
            prev_j_q    <= prev_j_d;
            state_q     <= state_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            end_q       <= end_d;
            error_q     <= error_d;
        end
    end

    // A pulse registered just before rx_en falls is masked so nothing
    // escapes while the receiver is disabled.
    assign line_state    = line_q;
    assign rx_data       = rx_data_q;
    assign pkt_start     = start_q & rx_en;
    assign rx_data_valid = valid_q & rx_en;
    assign pkt_end       = end_q & rx_en;
    assign pkt_error     = error_q & rx_en;

endmodule
